// File: rtl/fifo_drain.sv
// fifo_drain: pops a 1-cycle-latency FIFO read port into a 2-entry skid buffer and
// presents a valid/ready stream. Define FIFO_DRAIN_STATS_EN to add pop/stall counters.
module fifo_drain #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic             rd_clk,
  input  logic             rst,
  input  logic             drain_en,
  input  logic             empty,
  output logic             rd_en,
  input  logic [WIDTH-1:0] r_data,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef FIFO_DRAIN_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] pop_count,
  output logic [CNT_WIDTH-1:0] stall_count
`endif
);

  if (WIDTH < 1 || CNT_WIDTH < 1) begin : g_bad_param
    $error("fifo_drain: WIDTH and CNT_WIDTH must be positive");
  end

  logic             inflight_q, inflight_d;
  logic [1:0]       count_q, count_d;
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];

  logic       fire;
  logic [2:0] committed;

  // NOTE: every signal written here gets a default on entry, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    out_valid = (count_q != 2'd0);
    out_data  = mem_q[head_q];
    fire      = out_valid && out_ready;

    // Slots already promised: buffered words plus the word returning this cycle,
    // less the word leaving this cycle. Popping only below 2 keeps the skid safe.
    committed = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, fire};
    rd_en     = !rst && drain_en && !empty && (committed < 3'd2);

    inflight_d = rd_en;
    head_d     = head_q ^ fire;
    tail_d     = tail_q ^ inflight_q;

    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    if (inflight_q) begin
      mem_d[tail_q] = r_data;
    end

    count_d = count_q;
    unique case ({inflight_q, fire})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      // NOTE: the two storage words are reset so out_data reads zero after reset;
      // a deeper buffer would leave its storage unreset and mask the output instead.
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
    end else begin
      inflight_q <= inflight_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      mem_q[0]   <= mem_d[0];
      mem_q[1]   <= mem_d[1];
    end
  end

`ifdef FIFO_DRAIN_STATS_EN
  logic [CNT_WIDTH-1:0] pop_count_q, pop_count_d;
  logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;

  // Both counters wrap naturally at 2^CNT_WIDTH.
  always_comb begin
    pop_count_d   = pop_count_q + (rd_en ? CNT_WIDTH'(1) : CNT_WIDTH'(0));
    stall_count_d = stall_count_q + ((out_valid && !out_ready) ? CNT_WIDTH'(1) : CNT_WIDTH'(0));
  end

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      pop_count_q   <= '0;
      stall_count_q <= '0;
    end else begin
      pop_count_q   <= pop_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign pop_count   = pop_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// tb_fifo_drain: FIFO read-port model plus scoreboard around fifo_drain; directed
// vector table, hand-written corner sequences and a randomized stream.
module tb_fifo_drain;
  localparam int WIDTH     = 8;
  localparam int CNT_WIDTH = 16;

  logic             rd_clk    = 1'b0;
  logic             rst       = 1'b1;
  logic             drain_en  = 1'b0;
  logic             empty     = 1'b1;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] r_data    = '0;
  logic             rd_en;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
`ifdef FIFO_DRAIN_STATS_EN
  logic [CNT_WIDTH-1:0] pop_count;
  logic [CNT_WIDTH-1:0] stall_count;
`endif

  logic             wr_en   = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             rd_err  = 1'b0;
  logic [WIDTH-1:0] fifo_q[$];

  int   checks    = 0;
  int   errors    = 0;
  int   pops      = 0;
  int   delivered = 0;
  int   stalls    = 0;
  logic last_pop  = 1'b0;

  fifo_drain #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .rd_clk   (rd_clk),
    .rst      (rst),
    .drain_en (drain_en),
    .empty    (empty),
    .rd_en    (rd_en),
    .r_data   (r_data),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef FIFO_DRAIN_STATS_EN
    ,
    .pop_count  (pop_count),
    .stall_count(stall_count)
`endif
  );

  always #5 rd_clk = ~rd_clk;

  // FIFO read port: one cycle of read latency, registered empty flag.
  always @(posedge rd_clk) begin
    if (rst) begin
      fifo_q.delete();
      empty <= 1'b1;
    end else begin
      if (rd_en) begin
        if (fifo_q.size() == 0) rd_err <= 1'b1;
        else r_data <= fifo_q.pop_front();
      end
      if (wr_en) fifo_q.push_back(wr_data);
      empty <= (fifo_q.size() == 0);
    end
  end

  // Transaction counters for the reference model.
  always @(posedge rd_clk) begin
    if (rst) begin
      pops      <= 0;
      delivered <= 0;
      stalls    <= 0;
      last_pop  <= 1'b0;
    end else begin
      if (rd_en) pops <= pops + 1;
      if (out_valid && out_ready) delivered <= delivered + 1;
      if (out_valid && !out_ready) stalls <= stalls + 1;
      last_pop <= rd_en;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_stats(input int exp_pop, input int exp_stall);
`ifdef FIFO_DRAIN_STATS_EN
    check("pop_count", 32'(pop_count), 32'(exp_pop));
    check("stall_count", 32'(stall_count), 32'(exp_stall));
`endif
  endtask

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    drain_en  = 1'b0;
    out_ready = 1'b0;
    wr_en     = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push_words(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = WIDTH'(base + i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  typedef struct {
    logic             de;
    logic             rdy;
    logic             exp_rd;
    logic             exp_ov;
    logic [WIDTH-1:0] exp_data;
  } vec_t;

  vec_t tbl[13];
  logic [WIDTH-1:0] exp_words[$];

  initial begin
    int k;
    int guard;
    int wr_cnt;
    int rdy_cnt;
    int written;
    int outst;
    int avail;
    logic exp_ov;
    logic exp_rd;
    logic [11:0] tog_rd;
    logic [11:0] tog_ov;

    // Preloaded 0x00..0x0F: stall, release, drain_en low, restart.
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h00};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h01};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h02};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h03};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h04};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h05};

    // Reset values
    do_reset();
    #1;
    check("reset rd_en", 32'(rd_en), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", 32'(out_data), 32'd0);
    check_stats(0, 0);

    // Vector table
    push_words(0, 16);
    for (int i = 0; i < 13; i++) begin
      drain_en  = tbl[i].de;
      out_ready = tbl[i].rdy;
      #1;
      check($sformatf("tbl[%0d] rd_en", i), 32'(rd_en), 32'(tbl[i].exp_rd));
      check($sformatf("tbl[%0d] out_valid", i), 32'(out_valid), 32'(tbl[i].exp_ov));
      if (tbl[i].exp_ov)
        check($sformatf("tbl[%0d] out_data", i), 32'(out_data), 32'(tbl[i].exp_data));
      tick();
    end
    check_stats(8, 2);

    // Basic drain: 16 words on consecutive cycles, 2 cycles after the first pop
    do_reset();
    push_words(0, 16);
    for (int c = 0; c < 20; c++) begin
      drain_en  = 1'b1;
      out_ready = 1'b1;
      #1;
      check($sformatf("drain c%0d rd_en", c), 32'(rd_en), 32'(c < 16));
      check($sformatf("drain c%0d out_valid", c), 32'(out_valid), 32'(c >= 2 && c < 18));
      if (c >= 2 && c < 18) check($sformatf("drain c%0d out_data", c), 32'(out_data), 32'(c - 2));
      tick();
    end
    check_stats(16, 0);

    // Underflow guard
    do_reset();
    for (int c = 0; c < 12; c++) begin
      drain_en  = 1'b1;
      out_ready = 1'b1;
      #1;
      check($sformatf("uflow c%0d rd_en", c), 32'(rd_en), 32'd0);
      check($sformatf("uflow c%0d out_valid", c), 32'(out_valid), 32'd0);
      tick();
    end
    check("uflow rd_err", 32'(rd_err), 32'd0);

    // Back-pressure: 10 stalled cycles, then full in-order delivery
    do_reset();
    push_words(0, 16);
    k = 0;
    for (int c = 0; c < 10; c++) begin
      drain_en  = 1'b1;
      out_ready = 1'b0;
      #1;
      if (rd_en) k++;
      if (out_valid) check($sformatf("bp hold c%0d out_data", c), 32'(out_data), 32'h00);
      tick();
    end
    check("bp pops during stall", 32'(k), 32'd2);
    check_stats(2, 8);
    k = 0;
    guard = 0;
    while (k < 16 && guard < 40) begin
      out_ready = 1'b1;
      #1;
      if (out_valid) begin
        check($sformatf("bp word %0d", k), 32'(out_data), 32'(k));
        k++;
      end
      tick();
      guard++;
    end
    check("bp words delivered", 32'(k), 32'd16);

    // drain_en dropped right after a pop
    do_reset();
    push_words(8'h40, 4);
    tog_rd = 12'b0001_1100_0001;
    tog_ov = 12'b0111_0000_0100;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      drain_en  = (c == 0) || (c >= 6);
      out_ready = 1'b1;
      #1;
      check($sformatf("toggle c%0d rd_en", c), 32'(rd_en), 32'(tog_rd[c]));
      check($sformatf("toggle c%0d out_valid", c), 32'(out_valid), 32'(tog_ov[c]));
      if (tog_ov[c]) begin
        check($sformatf("toggle c%0d out_data", c), 32'(out_data), 32'(8'h40 + k));
        k++;
      end
      tick();
    end

    // Mid-operation reset with the skid full
    do_reset();
    push_words(8'h50, 4);
    for (int c = 0; c < 3; c++) begin
      drain_en  = 1'b1;
      out_ready = 1'b0;
      tick();
    end
    #1;
    check("mrst pre out_valid", 32'(out_valid), 32'd1);
    check("mrst pre out_data", 32'(out_data), 32'h50);
    rst       = 1'b1;
    out_ready = 1'b1;
    #1;
    check("mrst during rd_en", 32'(rd_en), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("mrst after out_valid", 32'(out_valid), 32'd0);
    check("mrst after rd_en", 32'(rd_en), 32'd0);
    check_stats(0, 0);
    drain_en = 1'b0;
    tick();
    push_words(8'h60, 3);
    k = 0;
    for (int c = 0; c < 10; c++) begin
      drain_en  = 1'b1;
      out_ready = 1'b1;
      #1;
      if (out_valid) begin
        check($sformatf("mrst word %0d", k), 32'(out_data), 32'(8'h60 + k));
        k++;
      end
      tick();
    end
    check("mrst words delivered", 32'(k), 32'd3);

    // Randomized stream against the transaction-level model
    do_reset();
    exp_words.delete();
    written = 0;
    wr_cnt  = 0;
    rdy_cnt = 0;
    guard   = 0;
    while (delivered < 200 && guard < 8000) begin
      wr_en = 1'b0;
      if (written < 200) begin
        if (wr_cnt == 0) begin
          wr_en   = 1'b1;
          wr_data = WIDTH'($urandom);
          exp_words.push_back(wr_data);
          written++;
          wr_cnt = $urandom_range(0, 7);
        end else begin
          wr_cnt--;
        end
      end
      if (rdy_cnt == 0) begin
        out_ready = ~out_ready;
        rdy_cnt   = $urandom_range(0, 11);
      end else begin
        rdy_cnt--;
      end
      drain_en = ($urandom_range(0, 7) != 0);
      #1;
      outst  = pops - delivered;
      avail  = pops - int'(last_pop) - delivered;
      exp_ov = (avail > 0);
      exp_rd = drain_en && !empty && ((outst - int'(exp_ov && out_ready)) < 2);
      check("rand rd_en", 32'(rd_en), 32'(exp_rd));
      check("rand out_valid", 32'(out_valid), 32'(exp_ov));
      if (exp_ov && delivered < exp_words.size())
        check($sformatf("rand word %0d", delivered), 32'(out_data), 32'(exp_words[delivered]));
      tick();
      guard++;
    end
    wr_en = 1'b0;
    check("rand words delivered", 32'(delivered), 32'd200);
    check("rand fifo left", 32'(fifo_q.size()), 32'd0);
    check("rand rd_err", 32'(rd_err), 32'd0);
    check_stats(pops, stalls);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
